// File: rtl/flash_host_pkg.sv
// Shared definitions for the flash host sequencer: opcodes, FSM states,
// address width and a small opcode classification helper.
package flash_host_pkg;

    localparam int ADDR_W = 22;

    // Flash host command encoding. 3'd6 is reserved and handled as a
    // single non-data transaction.
    localparam logic [2:0] OP_READ       = 3'd0;
    localparam logic [2:0] OP_WRITE      = 3'd1;
    localparam logic [2:0] OP_BLK_ERASE  = 3'd2;
    localparam logic [2:0] OP_SEC_ERASE  = 3'd3;
    localparam logic [2:0] OP_CHIP_ERASE = 3'd4;
    localparam logic [2:0] OP_READ_ID    = 3'd5;
    localparam logic [2:0] OP_RESET      = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_WR,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_DELIVER,
        ST_NEXT,
        ST_FINISH
    } state_e;

    // Only READ and WRITE move a byte stream; everything else is one shot.
    function automatic logic is_data_op(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/flash_host_sequencer.sv
// Host-side initiator for the flash controller command port. Takes one
// descriptor (op, address, length) and runs one Start/Ready handshake per
// byte, streaming write bytes in and read bytes out.
module flash_host_sequencer
    import flash_host_pkg::*;
#(
    parameter int          LEN_W   = 16,
    parameter logic [31:0] TIMEOUT = 32'd0,
    parameter int          TO_W    = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCmd_Valid,
    output logic              oCmd_Ready,
    input  logic [2:0]        iCmd_Op,
    input  logic [ADDR_W-1:0] iCmd_Addr,
    input  logic [LEN_W-1:0]  iCmd_Len,
    input  logic [7:0]        iWr_Data,
    input  logic              iWr_Valid,
    output logic              oWr_Ready,
    output logic [7:0]        oRd_Data,
    output logic              oRd_Valid,
    input  logic              iRd_Ready,
    output logic              oDone,
    output logic              oErr,
    output logic [ADDR_W-1:0] oHS_ADDR,
    output logic [7:0]        oHS_DATA,
    output logic [2:0]        oHS_CMD,
    output logic              oHS_Start,
    input  logic              iHS_Ready,
    input  logic [7:0]        iHS_DATA
);

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                tmo_hit;

    // The Start cycle counts as the first elapsed cycle, so with TIMEOUT=N
    // the aborting oDone lands exactly N cycles after the Start strobe.
    assign tmo_hit = (TIMEOUT != 32'd0) &&
                     (cnt_q >= (TO_W'(TIMEOUT) - TO_W'(1)));

    assign oHS_ADDR = addr_q;
    assign oHS_DATA = wdata_q;
    assign oHS_CMD  = op_q;
    assign oRd_Data = rdata_q;

    // State and datapath registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update for the descriptor / per-byte loop
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (iCmd_Valid) begin
                    op_d   = iCmd_Op;
                    addr_d = iCmd_Addr;
                    err_d  = 1'b0;
                    if (is_data_op(iCmd_Op)) begin
                        rem_d = iCmd_Len;
                        if (iCmd_Len == '0)
                            state_d = ST_FINISH;
                        else if (iCmd_Op == OP_WRITE)
                            state_d = ST_GET_WR;
                        else
                            state_d = ST_ISSUE;
                    end else begin
                        rem_d   = LEN_W'(1);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_GET_WR: begin
                if (iWr_Valid) begin
                    wdata_d = iWr_Data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Never strobe Start into a busy port.
                if (iHS_Ready) begin
                    cnt_d   = TO_W'(1);
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                cnt_d = cnt_q + TO_W'(1);
                // Ack requires an observed low cycle on iHS_Ready.
                if (!iHS_Ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_q + TO_W'(1);
                if (iHS_Ready) begin
                    if (op_q == OP_READ) begin
                        rdata_d = iHS_DATA;
                        state_d = ST_DELIVER;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end
            end
            ST_DELIVER: begin
                if (iRd_Ready)
                    state_d = ST_NEXT;
            end
            ST_NEXT: begin
                rem_d  = rem_q - LEN_W'(1);
                addr_d = addr_q + ADDR_W'(1);
                if (rem_q == LEN_W'(1))
                    state_d = ST_FINISH;
                else if (op_q == OP_WRITE)
                    state_d = ST_GET_WR;
                else
                    state_d = ST_ISSUE;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        oCmd_Ready = 1'b0;
        oWr_Ready  = 1'b0;
        oRd_Valid  = 1'b0;
        oHS_Start  = 1'b0;
        oDone      = 1'b0;
        oErr       = 1'b0;
        case (state_q)
            ST_IDLE:    oCmd_Ready = 1'b1;
            ST_GET_WR:  oWr_Ready  = 1'b1;
            ST_ISSUE:   oHS_Start  = iHS_Ready;
            ST_DELIVER: oRd_Valid  = 1'b1;
            ST_FINISH: begin
                oDone = 1'b1;
                oErr  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flash_host_sequencer.sv
// Directed bench for flash_host_sequencer with a small flash host model
// that answers each Start with a configurable busy window.
module tb_flash_host_sequencer;
    import flash_host_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iCmd_Valid = 1'b0;
    logic        oCmd_Ready;
    logic [2:0]  iCmd_Op = 3'd0;
    logic [21:0] iCmd_Addr = '0;
    logic [15:0] iCmd_Len = '0;
    logic [7:0]  iWr_Data = '0;
    logic        iWr_Valid = 1'b0;
    logic        oWr_Ready;
    logic [7:0]  oRd_Data;
    logic        oRd_Valid;
    logic        iRd_Ready = 1'b1;
    logic        oDone, oErr;
    logic [21:0] oHS_ADDR;
    logic [7:0]  oHS_DATA;
    logic [2:0]  oHS_CMD;
    logic        oHS_Start;
    logic        iHS_Ready;
    logic [7:0]  iHS_DATA;

    flash_host_sequencer #(.LEN_W(16), .TIMEOUT(32'd20), .TO_W(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Op(iCmd_Op),
        .iCmd_Addr(iCmd_Addr), .iCmd_Len(iCmd_Len),
        .iWr_Data(iWr_Data), .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready),
        .oRd_Data(oRd_Data), .oRd_Valid(oRd_Valid), .iRd_Ready(iRd_Ready),
        .oDone(oDone), .oErr(oErr),
        .oHS_ADDR(oHS_ADDR), .oHS_DATA(oHS_DATA), .oHS_CMD(oHS_CMD),
        .oHS_Start(oHS_Start), .iHS_Ready(iHS_Ready), .iHS_DATA(iHS_DATA)
    );

    always #5 iCLK = ~iCLK;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    // Monitor state (written only by the monitor process)
    logic [21:0] st_addr[$];
    logic [2:0]  st_cmd[$];
    logic [7:0]  st_data[$];
    int          st_cyc[$];
    logic [7:0]  rd_q[$];
    int          done_n = 0, err_n = 0, err_alone = 0, done_cyc = 0;

    // Flash model controls (written only by the main sequence)
    int          busy_n = 2;
    bit          hang = 1'b0;
    bit          hold_low = 1'b0;
    logic [7:0]  dbase = 8'h00;
    int          didx = 0;
    int          served = 0;
    int          left = 0;

    initial forever begin
        @(posedge iCLK);
        cyc++;
    end

    // Monitor: sample outputs mid-cycle
    initial forever begin
        @(negedge iCLK);
        if (oHS_Start) begin
            st_addr.push_back(oHS_ADDR);
            st_cmd.push_back(oHS_CMD);
            st_data.push_back(oHS_DATA);
            st_cyc.push_back(cyc);
        end
        if (oRd_Valid && iRd_Ready) rd_q.push_back(oRd_Data);
        if (oDone) begin
            done_n++;
            done_cyc = cyc;
            if (oErr) err_n++;
        end else if (oErr) begin
            err_alone++;
        end
    end

    // Flash host model: ready drops the cycle after Start for busy_n cycles
    initial begin
        iHS_Ready = 1'b1;
        iHS_DATA  = 8'h00;
        forever begin
            @(posedge iCLK); #1;
            if (served < st_addr.size()) begin
                if (!hang) begin
                    left = busy_n;
                    iHS_DATA = dbase + 8'(served - didx);
                end
                served++;
            end
            if (left > 0) begin
                iHS_Ready = 1'b0;
                left--;
            end else begin
                iHS_Ready = !hold_low;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_desc(input logic [2:0] op, input logic [21:0] a, input logic [15:0] len);
        int k = 0;
        @(posedge iCLK); #1;
        iCmd_Valid = 1'b1; iCmd_Op = op; iCmd_Addr = a; iCmd_Len = len;
        @(negedge iCLK);
        while (!oCmd_Ready && k < 100) begin
            @(negedge iCLK);
            k++;
        end
        check("desc_accept", 32'(oCmd_Ready), 32'd1);
        @(posedge iCLK); #1;
        iCmd_Valid = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, input int gap);
        int k = 0;
        repeat (gap) @(posedge iCLK);
        #1;
        iWr_Valid = 1'b1; iWr_Data = d;
        @(negedge iCLK);
        while (!oWr_Ready && k < 100) begin
            @(negedge iCLK);
            k++;
        end
        check("wr_accept", 32'(oWr_Ready), 32'd1);
        @(posedge iCLK); #1;
        iWr_Valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_n < target && k < 300) begin
            @(posedge iCLK);
            k++;
        end
        check(tag, 32'(done_n), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, r, d0, e0, k;
        logic [7:0] held;

        // Reset state
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b0;
        @(negedge iCLK);
        check("rst_cmd_ready", 32'(oCmd_Ready), 32'd1);
        check("rst_wr_ready",  32'(oWr_Ready),  32'd0);
        check("rst_rd_valid",  32'(oRd_Valid),  32'd0);
        check("rst_done_err",  32'({oDone, oErr}), 32'd0);
        check("rst_start",     32'(oHS_Start),  32'd0);
        check("rst_hs_addr",   32'(oHS_ADDR),   32'd0);
        check("rst_hs_data_cmd", 32'({oHS_DATA, oHS_CMD}), 32'd0);
        check("rst_rd_data",   32'(oRd_Data),   32'd0);

        // READ 0x10, len 3, data A0..A2
        b = st_addr.size(); r = rd_q.size(); d0 = done_n; e0 = err_n;
        dbase = 8'hA0; didx = b; busy_n = 2;
        send_desc(OP_READ, 22'h000010, 16'd3);
        wait_done(d0 + 1, "rd3_done");
        repeat (4) @(posedge iCLK);
        check("rd3_single_done", 32'(done_n), 32'(d0 + 1));
        check("rd3_no_err", 32'(err_n), 32'(e0));
        check("rd3_nstart", 32'(st_addr.size()), 32'(b + 3));
        for (int i = 0; i < 3; i++) begin
            check("rd3_addr", 32'(st_addr[b+i]), 32'h10 + 32'(i));
            check("rd3_cmd",  32'(st_cmd[b+i]), 32'(OP_READ));
            check("rd3_byte", 32'(rd_q[r+i]), 32'hA0 + 32'(i));
        end

        // WRITE at 0x3FFFFF, len 2, gapped stream: address wraps to 0
        b = st_addr.size(); d0 = done_n;
        send_desc(OP_WRITE, 22'h3FFFFF, 16'd2);
        write_byte(8'h55, 3);
        write_byte(8'hAA, 2);
        wait_done(d0 + 1, "wr2_done");
        check("wr2_nstart", 32'(st_addr.size()), 32'(b + 2));
        check("wr2_addr0", 32'(st_addr[b]),   32'h3FFFFF);
        check("wr2_addr1", 32'(st_addr[b+1]), 32'h000000);
        check("wr2_data0", 32'(st_data[b]),   32'h55);
        check("wr2_data1", 32'(st_data[b+1]), 32'hAA);
        check("wr2_cmd0",  32'(st_cmd[b]),    32'(OP_WRITE));
        check("wr2_cmd1",  32'(st_cmd[b+1]),  32'(OP_WRITE));

        // SEC_ERASE ignores Len: exactly one Start
        b = st_addr.size(); d0 = done_n;
        send_desc(OP_SEC_ERASE, 22'h010000, 16'd100);
        wait_done(d0 + 1, "se_done");
        repeat (6) @(posedge iCLK);
        check("se_nstart", 32'(st_addr.size()), 32'(b + 1));
        check("se_cmd",  32'(st_cmd[b]),  32'(OP_SEC_ERASE));
        check("se_addr", 32'(st_addr[b]), 32'h010000);
        check("se_single_done", 32'(done_n), 32'(d0 + 1));

        // READ len 2 with consumer backpressure
        b = st_addr.size(); r = rd_q.size(); d0 = done_n;
        dbase = 8'h30; didx = b;
        iRd_Ready = 1'b0;
        send_desc(OP_READ, 22'h000400, 16'd2);
        k = 0;
        @(negedge iCLK);
        while (!oRd_Valid && k < 100) begin
            @(negedge iCLK);
            k++;
        end
        check("bp_valid_seen", 32'(oRd_Valid), 32'd1);
        held = 8'h30;
        for (int i = 0; i < 10; i++) begin
            @(negedge iCLK);
            check("bp_valid_held", 32'(oRd_Valid), 32'd1);
            check("bp_data_held",  32'(oRd_Data), 32'(held));
            check("bp_no_2nd_start", 32'(st_addr.size()), 32'(b + 1));
        end
        @(posedge iCLK); #1 iRd_Ready = 1'b1;
        wait_done(d0 + 1, "bp_done");
        check("bp_nstart", 32'(st_addr.size()), 32'(b + 2));
        check("bp_addr1", 32'(st_addr[b+1]), 32'h000401);
        check("bp_nbytes", 32'(rd_q.size()), 32'(r + 2));
        check("bp_byte0", 32'(rd_q[r]),   32'h30);
        check("bp_byte1", 32'(rd_q[r+1]), 32'h31);

        // Timeout: model never acks, abort 20 cycles after Start
        b = st_addr.size(); r = rd_q.size(); d0 = done_n; e0 = err_n;
        hang = 1'b1;
        send_desc(OP_READ, 22'h000800, 16'd2);
        wait_done(d0 + 1, "to_done");
        check("to_err_with_done", 32'(err_n), 32'(e0 + 1));
        check("to_latency", 32'(done_cyc - st_cyc[b]), 32'd20);
        @(negedge iCLK);
        check("to_idle_ready", 32'(oCmd_Ready), 32'd1);
        repeat (4) @(posedge iCLK);
        check("to_nstart", 32'(st_addr.size()), 32'(b + 1));
        check("to_no_rd_byte", 32'(rd_q.size()), 32'(r));
        check("to_err_alone", 32'(err_alone), 32'd0);
        hang = 1'b0;

        // Reset in WAIT_DONE abandons the transfer
        b = st_addr.size(); d0 = done_n;
        busy_n = 8;
        send_desc(OP_READ, 22'h000200, 16'd2);
        k = 0;
        while (st_addr.size() == b && k < 100) begin
            @(posedge iCLK);
            k++;
        end
        check("rst_mid_started", 32'(st_addr.size()), 32'(b + 1));
        repeat (3) @(posedge iCLK);
        #1 iRST = 1'b1; hold_low = 1'b1;
        @(posedge iCLK); #1 iRST = 1'b0;
        @(negedge iCLK);
        check("rst_mid_start", 32'(oHS_Start), 32'd0);
        check("rst_mid_cmd_ready", 32'(oCmd_Ready), 32'd1);
        check("rst_mid_rd_valid", 32'(oRd_Valid), 32'd0);
        repeat (5) @(posedge iCLK);
        check("rst_mid_no_done", 32'(done_n), 32'(d0));
        check("rst_mid_no_start", 32'(st_addr.size()), 32'(b + 1));
        send_desc(OP_SEC_ERASE, 22'h000123, 16'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            check("rst_busy_no_start", 32'(oHS_Start), 32'd0);
        end
        check("rst_busy_nstart", 32'(st_addr.size()), 32'(b + 1));
        @(posedge iCLK); #1 hold_low = 1'b0;
        wait_done(d0 + 1, "rst_new_done");
        check("rst_new_nstart", 32'(st_addr.size()), 32'(b + 2));
        check("rst_new_addr", 32'(st_addr[b+1]), 32'h000123);
        check("rst_new_cmd",  32'(st_cmd[b+1]),  32'(OP_SEC_ERASE));

        repeat (3) @(posedge iCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
